bias_sched: RTL and testbench

Read-side scheduler for the clk_100M side of the bias CDC FIFO (512-bit words = 16 x 32-bit output-channel biases).
- Replaces free-running "read whenever non-empty" with layer-sequenced fetches.
- Pops exactly one bias word per output-channel group and holds it stable while the conv engine consumes that group's pixel beats.
- Signals layer completion and flags consumer underruns.

---
 rtl/bias_sched.sv | 104 ++++++++++
 tb/tb_bias_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_sched.sv
// Read-side scheduler for the bias CDC FIFO: one bias word per channel group,
// held stable while the conv engine consumes that group's pixel beats.
module bias_sched #(
  parameter int DATA_W = 512,
  parameter int GRP_W  = 10,
  parameter int PIX_W  = 16
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [GRP_W-1:0]  cfg_grp_num,
  input  logic [PIX_W-1:0]  cfg_pix_num,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              pix_beat,
  output logic              bias_vld,
  output logic [DATA_W-1:0] bias_data,
  output logic              busy,
  output logic              layer_done,
  output logic              underrun_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state;
  logic [GRP_W-1:0] grp_num;
  logic [GRP_W-1:0] grp_cnt;
  logic [PIX_W-1:0] pix_num;
  logic [PIX_W-1:0] pix_cnt;
  logic             grp_last;
  logic             pix_last;

  assign fifo_rd_en = (state == S_FETCH) && !fifo_empty;
  assign busy       = (state != S_IDLE);
  assign bias_vld   = (state == S_HOLD);
  assign layer_done = (state == S_DONE);

  assign grp_last = (grp_cnt == grp_num - GRP_W'(1));
  assign pix_last = (pix_cnt == pix_num - PIX_W'(1));

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      grp_num      <= '0;
      grp_cnt      <= '0;
      pix_num      <= '0;
      pix_cnt      <= '0;
      bias_data    <= '0;
      underrun_err <= 1'b0;
    end else begin
      // Beats arriving without a valid bias are dropped, only flagged.
      if (busy && pix_beat && !bias_vld)
        underrun_err <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            grp_num      <= cfg_grp_num;
            pix_num      <= (cfg_pix_num == '0) ? PIX_W'(1)
                                                : cfg_pix_num;
            grp_cnt      <= '0;
            pix_cnt      <= '0;
            underrun_err <= 1'b0;
            state        <= (cfg_grp_num == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (fifo_rd_en)
            state <= S_WAIT;
        end
        S_WAIT: begin
          bias_data <= fifo_q;
          pix_cnt   <= '0;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (pix_beat) begin
            if (!pix_last) begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end else if (grp_last) begin
              state <= S_DONE;
            end else begin
              grp_cnt <= grp_cnt + GRP_W'(1);
              state   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bias_sched.sv
// Bench for bias_sched: FIFO model, in-order bias-word scoreboard,
// per-scenario tasks with inline checks.
module tb_bias_sched;
  localparam int DW = 512;
  localparam int GW = 10;
  localparam int PW = 16;

  logic          clk_100M = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [GW-1:0] cfg_grp_num = '0;
  logic [PW-1:0] cfg_pix_num = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_q = '0;
  logic          pix_beat = 1'b0;
  logic          bias_vld;
  logic [DW-1:0] bias_data;
  logic          busy;
  logic          layer_done;
  logic          underrun_err;

  bias_sched dut (
    .clk_100M    (clk_100M),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_grp_num (cfg_grp_num),
    .cfg_pix_num (cfg_pix_num),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_q      (fifo_q),
    .pix_beat    (pix_beat),
    .bias_vld    (bias_vld),
    .bias_data   (bias_data),
    .busy        (busy),
    .layer_done  (layer_done),
    .underrun_err(underrun_err)
  );

  always #5 clk_100M = ~clk_100M;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_rd, n_beat, n_busy, n_done, n_rise;
  int rd_cyc, vld_cyc, done_cyc, beat_cyc, fall_cyc, gap;
  logic rd_s = 1'b0;
  logic prev_vld = 1'b0;

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clr();
    n_rd = 0; n_beat = 0; n_busy = 0; n_done = 0; n_rise = 0;
    rd_cyc = -1; vld_cyc = -1; done_cyc = -1; beat_cyc = -1;
    fall_cyc = -1; gap = -1;
  endtask

  task automatic sample();
    logic [DW-1:0] e;
    rd_s = fifo_rd_en;
    if (fifo_rd_en) begin
      n_rd++;
      rd_cyc = cyc;
      checks++;
      if (fifo_empty) begin
        errors++;
        $display("FAIL rd_while_empty: rd_en=1 empty=%0b", fifo_empty);
      end
    end
    if (pix_beat && bias_vld) begin n_beat++; beat_cyc = cyc; end
    if (busy) n_busy++;
    if (layer_done) begin n_done++; done_cyc = cyc; end
    if (prev_vld && !bias_vld) fall_cyc = cyc;
    if (!prev_vld && bias_vld) begin
      n_rise++;
      vld_cyc = cyc;
      if (fall_cyc >= 0) gap = cyc - fall_cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bias_word: got=%h with no expected word", bias_data);
      end else begin
        e = exp_q.pop_front();
        if (bias_data !== e) begin
          errors++;
          $display("FAIL bias_word: got=%h exp=%h", bias_data, e);
        end
      end
      held = bias_data;
    end else if (prev_vld && bias_vld) begin
      checks++;
      if (bias_data !== held) begin
        errors++;
        $display("FAIL bias_hold: got=%h exp=%h", bias_data, held);
      end
    end
    prev_vld = bias_vld;
  endtask

  task automatic tick();
    @(negedge clk_100M);
    sample();
    @(posedge clk_100M);
    #1;
    if (rd_s && fq.size() > 0) fifo_q = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  // mode 0: beat whenever bias valid; mode 1: beat every cycle
  task automatic run_layer(input int grp, input int pix, input int mode,
                           input int fill_at, output int start_cyc,
                           output int fill_cyc);
    int d0;
    cfg_grp_num = GW'(grp);
    cfg_pix_num = PW'(pix);
    cfg_start = 1'b1;
    start_cyc = cyc;
    fill_cyc = -1;
    pix_beat = (mode == 1);
    tick();
    cfg_start = 1'b0;
    d0 = n_done;
    for (int i = 0; i < 300; i++) begin
      if (i == fill_at) begin push(rnd_word()); fill_cyc = cyc; end
      pix_beat = (mode == 1) ? 1'b1 : bias_vld;
      tick();
      if (n_done != d0) break;
    end
    pix_beat = 1'b0;
    checks++;
    if (n_done != d0 + 1) begin
      errors++;
      $display("FAIL layer_timeout: done=%0d exp=%0d", n_done, d0 + 1);
    end
  endtask

  task automatic test_reset();
    clr();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({fifo_rd_en, bias_vld, busy, layer_done, underrun_err} !== 5'b0
        || bias_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%0b vld=%0b busy=%0b done=%0b err=%0b",
               fifo_rd_en, bias_vld, busy, layer_done, underrun_err);
    end
    push(rnd_word());
    push(rnd_word());
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (n_rd != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL idle_after_reset: reads=%0d busy=%0d exp 0", n_rd, n_busy);
    end
  endtask

  task automatic test_basic();
    int s, f;
    clr();
    run_layer(2, 3, 0, -1, s, f);
    checks++;
    if (n_rd != 2) begin
      errors++; $display("FAIL basic_reads: got=%0d exp=2", n_rd);
    end
    checks++;
    if (n_beat != 6) begin
      errors++; $display("FAIL basic_beats: got=%0d exp=6", n_beat);
    end
    checks++;
    if (gap != 2) begin
      errors++; $display("FAIL basic_bubble: got=%0d exp=2", gap);
    end
    checks++;
    if (done_cyc - beat_cyc != 1) begin
      errors++;
      $display("FAIL basic_done_lat: got=%0d exp=1", done_cyc - beat_cyc);
    end
    checks++;
    if (busy !== 1'b0 || underrun_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: busy=%0b err=%0b exp 0 0", busy, underrun_err);
    end
  endtask

  task automatic test_empty_stall();
    int s, f;
    clr();
    run_layer(1, 1, 0, 10, s, f);
    checks++;
    if (n_rd != 1 || rd_cyc < f) begin
      errors++;
      $display("FAIL stall_read: reads=%0d at=%0d fill=%0d", n_rd, rd_cyc, f);
    end
    checks++;
    if (vld_cyc - rd_cyc != 2) begin
      errors++;
      $display("FAIL stall_vld_lat: got=%0d exp=2", vld_cyc - rd_cyc);
    end
    checks++;
    if (n_beat != 1 || done_cyc - beat_cyc != 1) begin
      errors++;
      $display("FAIL stall_done: beats=%0d lat=%0d exp 1 1",
               n_beat, done_cyc - beat_cyc);
    end
  endtask

  task automatic test_zero_grp();
    int s, f;
    clr();
    push(rnd_word());
    run_layer(0, 5, 0, -1, s, f);
    checks++;
    if (n_rd != 0) begin
      errors++; $display("FAIL zero_grp_reads: got=%0d exp=0", n_rd);
    end
    checks++;
    if (n_busy != 1 || done_cyc != s + 1) begin
      errors++;
      $display("FAIL zero_grp_timing: busy=%0d done_at=%0d exp 1 %0d",
               n_busy, done_cyc, s + 1);
    end
  endtask

  task automatic test_underrun();
    int s, f;
    clr();
    push(rnd_word());
    run_layer(2, 2, 1, -1, s, f);
    checks++;
    if (n_beat != 4 || n_rd != 2) begin
      errors++;
      $display("FAIL underrun_counts: beats=%0d reads=%0d exp 4 2",
               n_beat, n_rd);
    end
    checks++;
    if (underrun_err !== 1'b1) begin
      errors++; $display("FAIL underrun_flag: got=%0b exp=1", underrun_err);
    end
    tick(); tick();
    checks++;
    if (underrun_err !== 1'b1) begin
      errors++; $display("FAIL underrun_sticky: got=%0b exp=1", underrun_err);
    end
  endtask

  task automatic test_zero_pix();
    int s, f;
    clr();
    push(rnd_word());
    run_layer(1, 0, 0, -1, s, f);
    checks++;
    if (n_beat != 1 || n_rd != 1) begin
      errors++;
      $display("FAIL zero_pix: beats=%0d reads=%0d exp 1 1", n_beat, n_rd);
    end
    checks++;
    if (underrun_err !== 1'b0) begin
      errors++; $display("FAIL underrun_clear: got=%0b exp=0", underrun_err);
    end
  endtask

  task automatic test_abort();
    bit sent = 0;
    int s, f;
    clr();
    push(rnd_word()); push(rnd_word()); push(rnd_word());
    cfg_grp_num = GW'(3);
    cfg_pix_num = PW'(4);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (n_rise == 2) break;
      cfg_start = 1'b0;
      if (bias_vld && !sent) begin
        cfg_start = 1'b1;
        cfg_grp_num = GW'(1);
        cfg_pix_num = PW'(1);
        sent = 1;
      end
      pix_beat = bias_vld;
      tick();
    end
    cfg_start = 1'b0;
    pix_beat = 1'b0;
    checks++;
    if (n_beat != 5 || n_rd != 2 || bias_vld !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_cfg: beats=%0d reads=%0d vld=%0b busy=%0b",
               n_beat, n_rd, bias_vld, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, bias_vld, busy, layer_done, underrun_err} !== 5'b0
        || bias_data !== '0) begin
      errors++;
      $display("FAIL abort_outputs: vld=%0b busy=%0b data_nz=%0b",
               bias_vld, busy, bias_data != '0);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (n_rd != 2) begin
      errors++; $display("FAIL abort_no_read: got=%0d exp=2", n_rd);
    end
    clr();
    run_layer(1, 1, 0, -1, s, f);
    checks++;
    if (n_rd != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL after_abort: reads=%0d left=%0d exp 1 0",
               n_rd, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_stall();
    test_zero_grp();
    test_underrun();
    test_zero_pix();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
